// File: rtl/telemetry_framer_pkg.sv
// roversPackage: shared byte type, sync constants and frame-state encoding for the telemetry framer.
package roversPackage;
   typedef logic [7:0] bus08_t;
   localparam bus08_t SYNC0 = 8'hAA;
   localparam bus08_t SYNC1 = 8'h55;
   typedef enum logic [2:0] {IDLE, LOAD, SEND, GAP, DONE} frameState_t;
endpackage

// File: rtl/telemetry_framer_if.sv
// telemetry_framer_if: byte handshake between the framer (master) and a UART transmitter (slave).
interface telemetry_framer_if;
   import roversPackage::*;
   bus08_t outByte;
   logic dataReady;
   logic uartReady;
   modport master (output outByte, output dataReady, input uartReady);
   modport slave (input outByte, input dataReady, output uartReady);
endinterface

// File: rtl/telemetry_framer_rate_ticker.sv
// rate_ticker: one-cycle tick every CLKFREQ/RATE_HZ sclk cycles, counting 0..period-1.
module rate_ticker #(
   parameter int CLKFREQ = 100_000_000,
   parameter int RATE_HZ = 50
) (
   input  logic sclk,
   input  logic rstn,
   output logic tick
);
   localparam int PERIOD = (CLKFREQ / RATE_HZ < 1) ? 1 : CLKFREQ / RATE_HZ;
   localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   logic [CW-1:0] count;
   assign tick = count == CW'(PERIOD - 1);
   always_ff @(posedge sclk)
      if (!rstn || tick) count <= '0;
      else count <= count + CW'(1);
endmodule

// File: rtl/telemetry_framer.sv
// telemetry_framer: frames a chData snapshot as AA 55 SEQ LEN payload CHK over a ready/valid byte link.
module telemetry_framer
   import roversPackage::*;
#(
   parameter int CLKFREQ = 100_000_000,
   parameter int FRAME_HZ = 50,
   parameter bit AUTO_SEND = 1'b1,
   parameter int NUM_CH = 4,
   parameter int CH_BYTES = 2
) (
   input  logic sclk,
   input  logic rstn,
   telemetry_framer_if.master uart,
   input  logic sendReq,
   input  logic [NUM_CH*CH_BYTES*8-1:0] chData,
   output logic busy,
   output logic frameDone,
   output logic [7:0] overrunCount
);
   localparam int LEN = NUM_CH * CH_BYTES;
   localparam int LAST = LEN + 4;
   localparam int IW = $clog2(LAST + 1);
   frameState_t state;
   logic [LEN*8-1:0] snap, frameBuf;
   logic [IW-1:0] idx;
   bus08_t seq, chk, curByte;
   logic pending, tick, trigger, xfer;
   rate_ticker #(.CLKFREQ(CLKFREQ), .RATE_HZ(FRAME_HZ)) ticker (.sclk(sclk), .rstn(rstn), .tick(tick));
   assign trigger = sendReq | (AUTO_SEND & tick);
   assign xfer = uart.dataReady & uart.uartReady;
   // Payload is reordered at snapshot time so the next byte to send always sits in frameBuf[7:0].
   always_comb begin
      snap = '0;
      for (int c = 0; c < NUM_CH; c++)
         for (int j = 0; j < CH_BYTES; j++)
            snap[(c*CH_BYTES + j)*8 +: 8] = chData[(c*CH_BYTES + CH_BYTES - 1 - j)*8 +: 8];
   end
   assign curByte = (idx == IW'(0)) ? SYNC0 :
                    (idx == IW'(1)) ? SYNC1 :
                    (idx == IW'(2)) ? seq :
                    (idx == IW'(3)) ? bus08_t'(LEN) :
                    (idx == IW'(LAST)) ? chk : frameBuf[7:0];
   assign uart.dataReady = state == SEND;
   assign uart.outByte = (state == SEND) ? curByte : 8'h00;
   assign busy = (state == LOAD) || (state == SEND) || (state == GAP);
   assign frameDone = state == DONE;
   always_ff @(posedge sclk) begin
      if (!rstn) begin
         state <= IDLE;
         pending <= 1'b0;
         seq <= 8'h00;
         chk <= 8'h00;
         idx <= '0;
         overrunCount <= 8'h00;
      end else begin
         // LOAD consumes the waiting trigger, so a trigger landing in LOAD is kept rather than counted as dropped.
         pending <= trigger | (pending & (state != LOAD));
         if (trigger && pending && state != LOAD && overrunCount != 8'hFF)
            overrunCount <= overrunCount + 8'h01;
         case (state)
            IDLE: if (pending || trigger) state <= LOAD;
            LOAD: begin
               state <= SEND;
               idx <= '0;
               chk <= 8'h00;
               frameBuf <= snap;
            end
            SEND: if (xfer) begin
               state <= (idx == IW'(LAST)) ? DONE : GAP;
               idx <= idx + IW'(1);
               if (idx >= IW'(2) && idx < IW'(LAST)) chk <= chk + curByte;
               if (idx >= IW'(4) && idx < IW'(LAST)) frameBuf <= frameBuf >> 8;
            end
            GAP: state <= SEND;
            DONE: begin
               state <= IDLE;
               seq <= seq + 8'h01;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_telemetry_framer.sv
// tb_telemetry_framer: table, random and corner-sequence checks of telemetry_framer against a frame model.
module tb_telemetry_framer;
   import roversPackage::*;
   typedef struct {
      logic [31:0] data;
      int maxStall;
      bus08_t seq;
      bus08_t chk;
   } vec_t;
   logic sclk = 1'b0;
   always #5 sclk = ~sclk;
   logic rstn0, rstn1, sendReq0, sendReq1;
   logic [31:0] chData0, chData1;
   logic busy0, busy1, frameDone0, frameDone1;
   logic [7:0] ov0, ov1;
   telemetry_framer_if b0 ();
   telemetry_framer_if b1 ();
   telemetry_framer #(.AUTO_SEND(1'b0), .NUM_CH(2), .CH_BYTES(2)) dut0 (
      .sclk(sclk), .rstn(rstn0), .uart(b0), .sendReq(sendReq0), .chData(chData0),
      .busy(busy0), .frameDone(frameDone0), .overrunCount(ov0));
   telemetry_framer #(.CLKFREQ(1000), .FRAME_HZ(100), .AUTO_SEND(1'b1), .NUM_CH(2), .CH_BYTES(2)) dut1 (
      .sclk(sclk), .rstn(rstn1), .uart(b1), .sendReq(sendReq1), .chData(chData1),
      .busy(busy1), .frameDone(frameDone1), .overrunCount(ov1));
   int checks = 0;
   int errors = 0;
   bus08_t modelSeq = 8'h00;
   bus08_t expQ [$];
   bus08_t got [$];
   bus08_t got1 [$];
   vec_t vecs [5];
   bus08_t req30 [9] = '{8'hAA, 8'h55, 8'h00, 8'h04, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC2};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, act, req);
      end
   endtask

   function automatic bus08_t gotAt(input int i);
      return (i < got.size()) ? got[i] : 8'hxx;
   endfunction

   // Reference frame: sync bytes, SEQ, LEN, channels low-first with each channel MSB-first, then mod-256 sum.
   function automatic void buildFrame(input bus08_t s, input logic [31:0] d);
      bus08_t sum, b;
      expQ = {SYNC0, SYNC1, s, 8'd4};
      sum = s + 8'd4;
      for (int c = 0; c < 2; c++)
         for (int j = 1; j >= 0; j--) begin
            b = d[(c*2 + j)*8 +: 8];
            expQ.push_back(b);
            sum += b;
         end
      expQ.push_back(sum);
   endfunction

   task automatic sendFrame(input logic [31:0] d, input int maxStall, input bit pulse, input bit scramble);
      int stall;
      bit held, gap, done, first;
      bus08_t heldByte;
      chData0 = d;
      b0.uartReady = 1'b0;
      if (pulse) begin
         sendReq0 = 1'b1;
         @(negedge sclk);
         sendReq0 = 1'b0;
         check("load busy", {30'd0, b0.dataReady, busy0}, 32'd1);
      end
      got.delete();
      held = 0; gap = 0; done = 0; first = pulse; heldByte = 8'h00;
      stall = $urandom_range(0, maxStall);
      for (int c = 0; c < 3000 && !done; c++) begin
         @(negedge sclk);
         if (first) check("latency", {31'd0, b0.dataReady}, 32'd1);
         first = 0;
         if (gap) check("gap", {31'd0, b0.dataReady}, 32'd0);
         gap = 0;
         if (held) check("hold", {23'd0, b0.dataReady, b0.outByte}, {23'd0, 1'b1, heldByte});
         held = 0;
         if (frameDone0) begin
            done = 1;
            check("done busy", {31'd0, busy0}, 32'd0);
         end else if (b0.dataReady) begin
            if (scramble) chData0 = $urandom();
            if (stall > 0) begin
               b0.uartReady = 1'b0;
               stall--;
               held = 1;
               heldByte = b0.outByte;
            end else begin
               b0.uartReady = 1'b1;
               got.push_back(b0.outByte);
               gap = 1;
               stall = $urandom_range(0, maxStall);
            end
         end else b0.uartReady = 1'($urandom_range(0, 1));
      end
      check("frame done", {31'd0, done}, 32'd1);
      buildFrame(modelSeq, d);
      check("frame len", got.size(), expQ.size());
      for (int i = 0; i < expQ.size(); i++) check("frame byte", {24'd0, gotAt(i)}, {24'd0, expQ[i]});
      modelSeq++;
      @(negedge sclk);
      check("done pulse", {31'd0, frameDone0}, 32'd0);
   endtask

   initial begin
      int n;
      bit seenDr;
      vecs[0] = '{32'hABCD1234, 20, 8'h01, 8'hC3};
      vecs[1] = '{32'h00000000, 3, 8'h02, 8'h06};
      vecs[2] = '{32'hFFFFFFFF, 5, 8'h03, 8'h03};
      vecs[3] = '{32'h01020304, 1, 8'h04, 8'h12};
      vecs[4] = '{32'hABCD1234, 2, 8'h05, 8'hC7};
      rstn0 = 1'b0; rstn1 = 1'b0; sendReq0 = 1'b1; sendReq1 = 1'b0;
      chData0 = 32'h0; chData1 = 32'h0102A0B0;
      b0.uartReady = 1'b1; b1.uartReady = 1'b1;
      repeat (3) @(negedge sclk);
      check("rst dataReady", {31'd0, b0.dataReady}, 32'd0);
      check("rst outByte", {24'd0, b0.outByte}, 32'd0);
      check("rst busy/done", {30'd0, busy0, frameDone0}, 32'd0);
      check("rst overrun", {24'd0, ov0}, 32'd0);
      sendReq0 = 1'b0;
      rstn0 = 1'b1;
      repeat (2) @(negedge sclk);
      check("idle quiet", {30'd0, b0.dataReady, busy0}, 32'd0);
      sendFrame(32'hABCD1234, 0, 1, 1);
      for (int i = 0; i < 9; i++) check("req30 byte", {24'd0, gotAt(i)}, {24'd0, req30[i]});
      for (int v = 0; v < 5; v++) begin
         sendFrame(vecs[v].data, vecs[v].maxStall, 1, 1);
         check("tbl seq", {24'd0, gotAt(2)}, {24'd0, vecs[v].seq});
         check("tbl chk", {24'd0, gotAt(8)}, {24'd0, vecs[v].chk});
      end
      for (int f = 6; f < 256; f++) sendFrame($urandom(), 2, 1, 1);
      sendFrame($urandom(), 1, 1, 1);
      check("seq wrap", {24'd0, gotAt(2)}, 32'd0);
      // Back-to-back triggers: the one landing in LOAD must yield a second frame.
      chData0 = 32'h5A5AC3C3;
      b0.uartReady = 1'b0;
      sendReq0 = 1'b1;
      repeat (2) @(negedge sclk);
      sendReq0 = 1'b0;
      sendFrame(32'h5A5AC3C3, 1, 0, 0);
      sendFrame(32'h5A5AC3C3, 1, 0, 0);
      check("load retrigger ov", {24'd0, ov0}, 32'd0);
      b0.uartReady = 1'b0;
      for (int p = 0; p < 5; p++) begin
         sendReq0 = 1'b1;
         @(negedge sclk);
         sendReq0 = 1'b0;
         @(negedge sclk);
      end
      check("overrun 3", {24'd0, ov0}, 32'd3);
      for (int p = 0; p < 300; p++) begin
         sendReq0 = 1'b1;
         @(negedge sclk);
         sendReq0 = 1'b0;
         @(negedge sclk);
      end
      check("overrun sat", {24'd0, ov0}, 32'd255);
      rstn0 = 1'b0;
      @(negedge sclk);
      check("rst2 overrun", {24'd0, ov0}, 32'd0);
      check("rst2 outs", {22'd0, b0.dataReady, busy0, frameDone0, 1'b0, b0.outByte}, 32'd0);
      rstn0 = 1'b1;
      modelSeq = 8'h00;
      // Reset after the fourth byte must abandon the frame.
      chData0 = 32'h11223344;
      b0.uartReady = 1'b1;
      sendReq0 = 1'b1;
      @(negedge sclk);
      sendReq0 = 1'b0;
      n = 0;
      for (int c = 0; c < 100 && n < 4; c++) begin
         @(negedge sclk);
         if (b0.dataReady) n++;
      end
      check("four bytes", n, 32'd4);
      @(negedge sclk);
      rstn0 = 1'b0;
      @(negedge sclk);
      check("midrst outs", {22'd0, b0.dataReady, busy0, frameDone0, 1'b0, b0.outByte}, 32'd0);
      rstn0 = 1'b1;
      seenDr = 0;
      repeat (6) begin
         @(negedge sclk);
         seenDr |= b0.dataReady;
      end
      check("abandoned", {31'd0, seenDr}, 32'd0);
      sendFrame(32'h11223344, 0, 1, 0);
      // Automatic triggering: tick every 10 cycles, each 19-cycle frame leaves one tick dropped.
      n = 0;
      rstn1 = 1'b1;
      for (int t = 1; t <= 300; t++) begin
         @(negedge sclk);
         if (b1.dataReady) begin
            if (n == 0) n = t;
            got1.push_back(b1.outByte);
         end
      end
      check("auto latency", n, 32'd11);
      check("auto overrun", {24'd0, ov1}, (300 - 30) / 20 + 1);
      check("auto count", {31'd0, got1.size() >= 126}, 32'd1);
      for (int f = 0; f < 14; f++) begin
         buildFrame(bus08_t'(f), chData1);
         for (int i = 0; i < 9 && f*9 + i < got1.size(); i++)
            check("auto byte", {24'd0, got1[f*9 + i]}, {24'd0, expQ[i]});
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
